// File: rtl/aes_round_controller.sv
// ============================================================================
//  Module   : aes_round_controller
//  Purpose  : Iterative AES-128 round sequencer. It drives an external
//             key store and an external round datapath.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEYIDX_W   = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                inValid,
  output logic                inReady,
  input  logic [127:0]        inState,
  output logic [KEYIDX_W-1:0] keyIdx,
  input  logic [127:0]        roundKey,
  output logic [127:0]        roundIn,
  output logic                roundFinal,
  input  logic [127:0]        roundOut,
  output logic                outValid,
  input  logic                outReady,
  output logic [127:0]        outState,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [KEYIDX_W-1:0] C_LAST = KEYIDX_W'(NUM_ROUNDS);
  localparam logic [KEYIDX_W-1:0] C_ONE  = KEYIDX_W'(1);

  state_t               r_fsm;
  state_t               w_fsm_nxt;
  logic [KEYIDX_W-1:0]  r_rnd;
  logic [KEYIDX_W-1:0]  w_rnd_nxt;
  logic [127:0]         r_data;
  logic [127:0]         w_data_nxt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fsm  <= ST_IDLE;
      r_rnd  <= '0;
      r_data <= '0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_rnd  <= w_rnd_nxt;
      r_data <= w_data_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_rnd_nxt  = r_rnd;
    w_data_nxt = r_data;
    inReady    = 1'b0;
    keyIdx     = r_rnd;
    roundFinal = 1'b0;
    outValid   = 1'b0;

    case (r_fsm)
      ST_IDLE: begin
        inReady = 1'b1;
        keyIdx  = '0;
        // Initial AddRoundKey happens here, using key index 0.
        if (inValid) begin
          w_data_nxt = inState ^ roundKey;
          w_rnd_nxt  = C_ONE;
          w_fsm_nxt  = ST_ROUND;
        end
      end

      ST_ROUND: begin
        roundFinal = (r_rnd == C_LAST);
        w_data_nxt = roundOut;
        if (r_rnd == C_LAST) begin
          w_fsm_nxt = ST_DONE;
        end else begin
          w_rnd_nxt = r_rnd + C_ONE;
        end
      end

      ST_DONE: begin
        outValid = 1'b1;
        if (outReady) begin
          w_fsm_nxt = ST_IDLE;
          w_rnd_nxt = '0;
        end
      end

      default: begin
        w_fsm_nxt  = ST_IDLE;
        w_rnd_nxt  = '0;
        w_data_nxt = '0;
      end
    endcase
  end

  assign roundIn  = r_data;
  assign outState = r_data;
  assign busy     = (r_fsm != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_aes_round_controller.sv
// ============================================================================
//  Module   : tb_aes_round_controller
//  Purpose  : Scoreboard bench with a behavioural AES key store and round
//             datapath. Expected ciphertexts are the published FIPS-197 values.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_controller;

  localparam int NUM_ROUNDS = 10;
  localparam int KEYIDX_W   = 4;

  localparam logic [127:0] C_KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_CT1  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic                clock;
  logic                reset_n;
  logic                inValid;
  logic                inReady;
  logic [127:0]        inState;
  logic [KEYIDX_W-1:0] keyIdx;
  logic [127:0]        roundKey;
  logic [127:0]        roundIn;
  logic                roundFinal;
  logic [127:0]        roundOut;
  logic                outValid;
  logic                outReady;
  logic [127:0]        outState;
  logic                busy;

  aes_round_controller #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .KEYIDX_W   (KEYIDX_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .inValid    (inValid),
    .inReady    (inReady),
    .inState    (inState),
    .keyIdx     (keyIdx),
    .roundKey   (roundKey),
    .roundIn    (roundIn),
    .roundFinal (roundFinal),
    .roundOut   (roundOut),
    .outValid   (outValid),
    .outReady   (outReady),
    .outState   (outState),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0]   sbox [256];
  logic [127:0] rk   [2][11];
  logic         key_sel;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input int sel, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One full AES round: SubBytes, ShiftRows, MixColumns (unless final), AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (fin) begin
        b[4*c] = a0; b[4*c+1] = a1; b[4*c+2] = a2; b[4*c+3] = a3;
      end else begin
        b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  assign roundKey = (int'(keyIdx) <= NUM_ROUNDS) ? rk[key_sel][keyIdx] : '0;
  assign roundOut = aes_round(roundIn, roundKey, roundFinal);

  int           tests;
  int           fails;
  int           cyc;
  logic [127:0] cur_exp;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           acc_log [$];
  int           exp_k;
  logic         prev_valid;
  logic [127:0] held;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Issue side: record each accepted block with its expected ciphertext.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      acc_q.delete();
    end else if (inValid && inReady) begin
      exp_q.push_back(cur_exp);
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
  end

  // Response side: sequencing checks while rounding, data checks on output.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_k      = 1;
      prev_valid = 1'b0;
    end else begin
      if (inValid && inReady) exp_k = 1;
      if (busy && !outValid) begin
        chk("keyidx_seq", 128'(keyIdx), 128'(exp_k));
        chk("roundfinal", 128'(roundFinal), 128'(exp_k == NUM_ROUNDS));
        chk("round_inready", 128'(inReady), 128'(0));
        exp_k++;
      end
      if (exp_q.size() == 0) begin
        chk("spurious_outvalid", 128'(outValid), 128'(0));
      end else if (outValid) begin
        if (!prev_valid) begin
          chk("latency", 128'(cyc - acc_q[0]), 128'(NUM_ROUNDS + 1));
          held = outState;
        end else begin
          chk("outstate_stable", outState, held);
        end
        chk("done_inready", 128'(inReady), 128'(0));
        if (outReady) begin
          chk("ciphertext", outState, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      prev_valid = outValid && !outReady;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inready"},    128'(inReady),    128'(1));
    chk({tag, "_outvalid"},   128'(outValid),   128'(0));
    chk({tag, "_busy"},       128'(busy),       128'(0));
    chk({tag, "_keyidx"},     128'(keyIdx),     128'(0));
    chk({tag, "_roundfinal"}, 128'(roundFinal), 128'(0));
    chk({tag, "_outstate"},   outState,         128'(0));
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] ct);
    logic ok;
    ok      = 1'b0;
    inState = pt;
    cur_exp = ct;
    inValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (inReady) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 128'(ok), 128'(1));
    @(posedge clock); #1;
    inValid = 1'b0;
  endtask

  task automatic wait_outvalid();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (outValid) begin ok = 1'b1; break; end
    end
    chk("outvalid_timeout", 128'(ok), 128'(1));
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    chk("drain_timeout", 128'(ok), 128'(1));
    @(posedge clock); #1;
  endtask

  initial begin
    logic ok;
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    inValid = 1'b0;
    inState = '0;
    outReady = 1'b1;
    key_sel = 1'b0;
    cur_exp = '0;
    build_sbox();
    expand_key(0, C_KEY0);
    expand_key(1, C_KEY1);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("rst");
    @(posedge clock); #1;
    reset_n = 1'b1;

    // FIPS-197 C.1 with the consumer always ready.
    send(C_PT0, C_CT0);
    drain();

    // Backpressure: hold the result for 20 cycles.
    outReady = 1'b0;
    send(C_PT0, C_CT0);
    wait_outvalid();
    repeat (20) @(negedge clock);
    @(posedge clock); #1;
    outReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("bp_release_busy", 128'(busy), 128'(0));
    chk("bp_release_inready", 128'(inReady), 128'(1));
    @(posedge clock); #1;

    // Back-to-back with inValid held high; key store swaps between blocks.
    inState = C_PT0;
    cur_exp = C_CT0;
    inValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (inReady) begin ok = 1'b1; break; end
    end
    chk("b2b_first_accept", 128'(ok), 128'(1));
    @(posedge clock); #1;
    inState = C_PT1;
    cur_exp = C_CT1;
    wait_outvalid();
    @(posedge clock); #1;
    key_sel = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (inReady) begin ok = 1'b1; break; end
    end
    chk("b2b_second_accept", 128'(ok), 128'(1));
    @(posedge clock); #1;
    inValid = 1'b0;
    drain();
    if (acc_log.size() >= 2)
      chk("b2b_gap", 128'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]),
          128'(NUM_ROUNDS + 2));
    else
      chk("b2b_accept_count", 128'(acc_log.size()), 128'(2));

    // Reset in the middle of round 5, then a clean block.
    send(C_PT1, C_CT1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (keyIdx == 4'd4) begin ok = 1'b1; break; end
    end
    chk("reach_round4", 128'(ok), 128'(1));
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk_reset_outputs("midrst");
    repeat (15) @(negedge clock);
    @(posedge clock); #1;
    send(C_PT1, C_CT1);
    drain();

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_round_controller.md
AES_ROUND_CONTROLLER -- requirements
Module: aes_round_controller

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, giving the number of cipher rounds after the initial key add.
REQ-002 The block SHALL have parameter KEYIDX_W, default 4, giving the width of the round-key index.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port inValid, input, 1, which presents a plaintext block on inState.
REQ-006 The block SHALL have port inReady, output, 1, indicating the controller accepts a block this cycle.
REQ-007 The block SHALL have port inState, input, 128, the plaintext state_t.
REQ-008 The block SHALL have port keyIdx, output, KEYIDX_W, the round-key index driven to the external key store.
REQ-009 The block SHALL have port roundKey, input, 128, the key-store word for keyIdx, combinational same cycle.
REQ-010 The block SHALL have port roundIn, output, 128, the state presented to the external round datapath.
REQ-011 The block SHALL have port roundFinal, output, 1, telling the datapath to skip MixColumns this cycle.
REQ-012 The block SHALL have port roundOut, input, 128, the datapath result for roundIn/roundKey (key already added), combinational same cycle.
REQ-013 The block SHALL have port outValid, output, 1, indicating the ciphertext on outState is valid.
REQ-014 The block SHALL have port outReady, input, 1, the consumer's acceptance of outState.
REQ-015 The block SHALL have port outState, output, 128, the ciphertext.
REQ-016 The block SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ROUND and DONE, with a KEYIDX_W-bit round counter rnd and a 128-bit register stateReg.
REQ-018 In IDLE: inReady=1, keyIdx=0; on inValid&inReady, stateReg <= inState ^ roundKey, rnd <= 1, next state ROUND.
REQ-019 In IDLE with inValid=0: no state change; roundKey and inState SHALL be ignored.
REQ-020 In ROUND: inReady=0, keyIdx=rnd, roundIn=stateReg, roundFinal=(rnd==NUM_ROUNDS), stateReg <= roundOut each cycle.
REQ-021 In ROUND, rnd SHALL increment by 1 while rnd<NUM_ROUNDS; at rnd==NUM_ROUNDS the next state SHALL be DONE and rnd SHALL hold.
REQ-022 Exactly NUM_ROUNDS ROUND cycles SHALL occur per block; rnd SHALL never exceed NUM_ROUNDS or wrap.
REQ-023 In DONE: outValid=1, outState=stateReg, inReady=0; on outReady, next state SHALL be IDLE.
REQ-024 In DONE, outState SHALL be held stable while outReady=0 (backpressure of unbounded length).
REQ-025 Latency: a block accepted at edge T SHALL have outValid high from cycle T+NUM_ROUNDS+1 onward.
REQ-026 Throughput SHALL be one block per NUM_ROUNDS+2 cycles when outReady is held at 1; no accept SHALL occur in the DONE->IDLE cycle.
REQ-027 outValid SHALL be 0 in IDLE and ROUND; roundIn SHALL equal stateReg in all states; roundFinal SHALL be 0 outside ROUND.
REQ-028 inValid toggling while inReady=0 SHALL have no effect, and that block is not captured.
REQ-029 outReady asserted outside DONE SHALL have no effect.
REQ-030 busy SHALL equal (state!=IDLE).

Reset
REQ-031 With reset_n=0 at a rising edge, the FSM SHALL go to IDLE with rnd=0 and stateReg=0, taking priority over all other inputs.
REQ-032 After reset: inReady=1, outValid=0, busy=0, keyIdx=0, roundFinal=0, outState=0.
REQ-033 Reset asserted during ROUND or DONE SHALL discard the in-flight block, and no outValid pulse for it SHALL follow.

Verification
REQ-034 FIPS-197 C.1 (key 000102030405060708090a0b0c0d0e0f, bench key store and round model, outReady=1): plaintext 00112233445566778899aabbccddeeff -> outState 69c4e0d86a7b0430d8cdb78070b4c55a, outValid at T+11.
REQ-035 Sequencing check: keyIdx sequence 0,1,...,10 on consecutive cycles; roundFinal high only when keyIdx=10.
REQ-036 Backpressure: outReady=0 for 20 cycles after outValid -> outState constant and inReady=0 throughout; outReady=1 -> IDLE next cycle.
REQ-037 Back-to-back: inValid held high with two blocks and outReady=1 -> second accepted exactly 12 cycles after the first, with both ciphertexts correct.
REQ-038 Reset mid-operation: reset_n=0 for 1 cycle at round 5 -> IDLE, outputs at reset values, no outValid; the next block encrypts correctly.
